// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_DEFAULT_N = 32;

endpackage

// File: rtl/piso_if.sv
// Load handshake and serial frame bundle between a word source and the PISO transmitter.
interface piso_if
    import piso_pkg::*;
#(
    parameter int N = PISO_DEFAULT_N
) ();

    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] d;
    logic         en;
    logic         sout;
    logic         svalid;
    logic         slast;
    logic         busy;

    modport master (
        output load_valid, d, en,
        input  load_ready, sout, svalid, slast, busy
    );

    modport slave (
        input  load_valid, d, en,
        output load_ready, sout, svalid, slast, busy
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Beat counter for one frame: cleared on load, saturates at N-1 and flags the final data beat.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int N = PISO_DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic                 done,
    output logic [$clog2(N)-1:0] cnt
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    assign done = (cnt == LAST_CNT);

    // Count enabled data beats; never advances past the final beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt <= {CNT_W{1'b0}};
        end else if (inc && !done) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/piso_32bit_tx.sv
// Parallel-in serial-out transmitter with back-to-back framing.
// Optional even-parity trailer beat when PISO_PARITY_EN is defined.
module piso_32bit_tx
    import piso_pkg::*;
#(
    parameter int N         = PISO_DEFAULT_N,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic  clk,
    input  logic  reset_n,
    piso_if.slave bus
);

    localparam int CNT_W = $clog2(N);
`ifdef PISO_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    function automatic logic even_parity(input logic [N-1:0] w);
        return ^w;
    endfunction

    function automatic logic first_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] shift_once(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    piso_state_t      state_r;
    logic [N-1:0]     shreg_r;
    logic [N-1:0]     shifted_s;
    logic             sout_r;
    logic             svalid_r;
    logic             slast_r;
    logic             busy_r;
    logic             ready_idle_r;
    logic             handoff_r;
    logic             load_ready_s;
    logic             fire_s;
    logic             cnt_inc_s;
    logic             cnt_done_s;
    logic [CNT_W-1:0] cnt_s;
`ifdef PISO_PARITY_EN
    logic             parity_r;
`endif

    // The handoff beat is the only place where readiness follows EN within the cycle.
    assign load_ready_s = ready_idle_r | (handoff_r & bus.en);
    assign fire_s       = bus.load_valid & load_ready_s;
    assign cnt_inc_s    = bus.en & (state_r == SHIFT);
    assign shifted_s    = shift_once(shreg_r);

    assign bus.load_ready = load_ready_s;
    assign bus.sout       = sout_r;
    assign bus.svalid     = svalid_r;
    assign bus.slast      = slast_r;
    assign bus.busy       = busy_r;

    piso_bit_counter #(.N(N)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (fire_s),
        .inc     (cnt_inc_s),
        .done    (cnt_done_s),
        .cnt     (cnt_s)
    );

    // Frame FSM, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            shreg_r      <= {N{1'b0}};
            sout_r       <= 1'b0;
            svalid_r     <= 1'b0;
            slast_r      <= 1'b0;
            busy_r       <= 1'b0;
            ready_idle_r <= 1'b0;
            handoff_r    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else if (fire_s) begin
            state_r      <= SHIFT;
            shreg_r      <= bus.d;
            sout_r       <= first_bit(bus.d);
            svalid_r     <= 1'b1;
            slast_r      <= 1'b0;
            busy_r       <= 1'b1;
            ready_idle_r <= 1'b0;
            handoff_r    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r     <= even_parity(bus.d);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    ready_idle_r <= 1'b1;
                end
                SHIFT: begin
                    if (bus.en) begin
                        if (cnt_done_s) begin
`ifdef PISO_PARITY_EN
                            state_r   <= PARITY;
                            shreg_r   <= shifted_s;
                            sout_r    <= parity_r;
                            slast_r   <= 1'b1;
                            handoff_r <= 1'b1;
`else
                            state_r      <= IDLE;
                            shreg_r      <= {N{1'b0}};
                            sout_r       <= 1'b0;
                            svalid_r     <= 1'b0;
                            slast_r      <= 1'b0;
                            busy_r       <= 1'b0;
                            ready_idle_r <= 1'b1;
                            handoff_r    <= 1'b0;
`endif
                        end else begin
                            // The beat after cnt==N-2 is the last one unless parity follows.
                            shreg_r   <= shifted_s;
                            sout_r    <= first_bit(shifted_s);
                            slast_r   <= !HAS_PARITY && (cnt_s == CNT_W'(N - 2));
                            handoff_r <= !HAS_PARITY && (cnt_s == CNT_W'(N - 2));
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (bus.en) begin
                        state_r      <= IDLE;
                        shreg_r      <= {N{1'b0}};
                        sout_r       <= 1'b0;
                        svalid_r     <= 1'b0;
                        slast_r      <= 1'b0;
                        busy_r       <= 1'b0;
                        ready_idle_r <= 1'b1;
                        handoff_r    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r      <= IDLE;
                    shreg_r      <= {N{1'b0}};
                    sout_r       <= 1'b0;
                    svalid_r     <= 1'b0;
                    slast_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    ready_idle_r <= 1'b1;
                    handoff_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule
